// File: rtl/lsq_pkg.sv
// Shared encodings for the load/store queue: funct3 codes, memory width codes, FSM states.
package lsq_pkg;

  localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
  localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
  localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
  localparam logic [2:0] F3_BU = 3'b100;  // LBU
  localparam logic [2:0] F3_HU = 3'b101;  // LHU

  typedef enum logic [1:0] {
    WIDTH_BYTE = 2'd0,
    WIDTH_HALF = 2'd1,
    WIDTH_WORD = 2'd2
  } lsq_width_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } lsq_state_e;

  function automatic lsq_width_e width_of(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return WIDTH_BYTE;
      F3_H, F3_HU: return WIDTH_HALF;
      default:     return WIDTH_WORD;
    endcase
  endfunction

endpackage

// File: rtl/lsq_load_ext.sv
// Combinational load-data extension: sign/zero extends the returned word according to funct3.
module lsq_load_ext
  import lsq_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] value_o
);

  always_comb begin
    value_o = rdata_i;
    case (funct3_i)
      F3_B:    value_o = {{24{rdata_i[7]}}, rdata_i[7:0]};
      F3_H:    value_o = {{16{rdata_i[15]}}, rdata_i[15:0]};
      F3_BU:   value_o = {24'd0, rdata_i[7:0]};
      F3_HU:   value_o = {16'd0, rdata_i[15:0]};
      default: value_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_queue.sv
// In-order load/store queue issuing one memory access at a time from the head.
// Define LSQ_STATS_EN to add saturating completed-load/store counters.
module load_store_queue
  import lsq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        _clear,
  input  logic        _dp_ready,
  input  logic [4:0]  _dp_rob_id,
  input  logic [3:0]  _dp_type,
  output logic        _lsq_full,
  input  logic        _lsb_rs_ready,
  input  logic [4:0]  _lsb_rob_id,
  input  logic [31:0] _lsb_ptr_value,
  input  logic [31:0] _lsb_st_value,
  input  logic        _rob_commit_st,
  input  logic [4:0]  _rob_commit_rob_id,
  output logic        _st_ready,
  output logic [4:0]  _st_rob_id,
  output logic        _mem_req,
  output logic        _mem_we,
  output logic [31:0] _mem_addr,
  output logic [31:0] _mem_wdata,
  output logic [1:0]  _mem_width,
  input  logic        _mem_done,
  input  logic [31:0] _mem_rdata,
  output logic        _cdb_ls_ready,
  output logic [4:0]  _cdb_ls_rob_id,
  output logic [31:0] _cdb_ls_value
`ifdef LSQ_STATS_EN
  ,
  output logic [31:0] _stat_loads,
  output logic [31:0] _stat_stores
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] busy_q, is_store_q, addr_valid_q, committed_q;
  logic [2:0]       funct3_q [DEPTH];
  logic [4:0]       rob_id_q [DEPTH];
  logic [31:0]      addr_q   [DEPTH];
  logic [31:0]      data_q   [DEPTH];

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, n_keep;

  lsq_state_e  state_q;
  logic        inflight_load_q, suppress_q;
  logic [2:0]  inflight_f3_q;
  logic [4:0]  inflight_rob_q;

  logic        st_ready_q, mem_req_q, mem_we_q, cdb_ready_q;
  logic [4:0]  st_rob_id_q, cdb_rob_id_q;
  logic [31:0] mem_addr_q, mem_wdata_q, cdb_value_q;
  lsq_width_e  mem_width_q;

  logic [DEPTH-1:0] rs_hit, commit_hit;
  logic        full, head_ready, issue, pop, alloc, rs_store_hit;
  logic [31:0] ext_value;

  assign full = (count_q == CW'(DEPTH));

  // Committed stores always sit contiguously at the head, so n_keep is where a flush puts the tail.
  always_comb begin
    rs_hit     = '0;
    commit_hit = '0;
    n_keep     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rs_hit[i]     = _lsb_rs_ready && !_clear && busy_q[i] && (rob_id_q[i] == _lsb_rob_id);
      commit_hit[i] = _rob_commit_st && busy_q[i] && is_store_q[i] &&
                      (rob_id_q[i] == _rob_commit_rob_id);
      if (busy_q[i] && (committed_q[i] || commit_hit[i])) n_keep = n_keep + CW'(1);
    end
  end

  assign rs_store_hit = |(rs_hit & is_store_q);
  assign head_ready   = busy_q[head_q] &&
                        (is_store_q[head_q] ? committed_q[head_q] : addr_valid_q[head_q]);
  assign issue        = (state_q == ST_IDLE) && !_clear && head_ready;
  // A load flushed while in flight has already left the queue, so its completion pops nothing.
  assign pop          = (state_q == ST_WAIT_MEM) && _mem_done && !suppress_q &&
                        !(_clear && inflight_load_q);
  assign alloc        = _dp_ready && !_clear && (!full || pop);

  always_comb begin
    head_d = head_q + PW'(pop);
    if (_clear) begin
      tail_d  = head_q + n_keep[PW-1:0];
      count_d = n_keep - CW'(pop);
    end else begin
      tail_d  = tail_q + PW'(alloc);
      count_d = count_q + CW'(alloc) - CW'(pop);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q       <= '0;
      addr_valid_q <= '0;
      committed_q  <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
    end else if (rdy_in) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (rs_hit[i])     addr_valid_q[i] <= 1'b1;
        if (commit_hit[i]) committed_q[i]  <= 1'b1;
        if (_clear && !(committed_q[i] || commit_hit[i])) busy_q[i] <= 1'b0;
      end
      if (pop) busy_q[head_q] <= 1'b0;
      if (alloc) begin
        busy_q[tail_q]       <= 1'b1;
        addr_valid_q[tail_q] <= 1'b0;
        committed_q[tail_q]  <= 1'b0;
      end
    end
  end

  // NOTE: payload fields have no reset; each is written at allocation or address arrival and only read behind busy/addr_valid.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rs_hit[i]) begin
          addr_q[i] <= _lsb_ptr_value;
          data_q[i] <= _lsb_st_value;
        end
      end
      if (alloc) begin
        rob_id_q[tail_q]   <= _dp_rob_id;
        is_store_q[tail_q] <= _dp_type[3];
        funct3_q[tail_q]   <= _dp_type[2:0];
      end
    end
  end

  lsq_load_ext u_load_ext (
    .funct3_i (inflight_f3_q),
    .rdata_i  (_mem_rdata),
    .value_o  (ext_value)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q         <= ST_IDLE;
      inflight_load_q <= 1'b0;
      suppress_q      <= 1'b0;
      inflight_f3_q   <= '0;
      inflight_rob_q  <= '0;
      st_ready_q      <= 1'b0;
      st_rob_id_q     <= '0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_width_q     <= WIDTH_BYTE;
      cdb_ready_q     <= 1'b0;
      cdb_rob_id_q    <= '0;
      cdb_value_q     <= '0;
    end else if (rdy_in) begin
      mem_req_q   <= 1'b0;
      cdb_ready_q <= 1'b0;
      st_ready_q  <= rs_store_hit;
      if (rs_store_hit) st_rob_id_q <= _lsb_rob_id;
      case (state_q)
        ST_IDLE: begin
          if (issue) begin
            mem_req_q       <= 1'b1;
            mem_we_q        <= is_store_q[head_q];
            mem_addr_q      <= addr_q[head_q];
            mem_wdata_q     <= data_q[head_q];
            mem_width_q     <= width_of(funct3_q[head_q]);
            inflight_f3_q   <= funct3_q[head_q];
            inflight_rob_q  <= rob_id_q[head_q];
            inflight_load_q <= !is_store_q[head_q];
            suppress_q      <= 1'b0;
            state_q         <= ST_WAIT_MEM;
          end
        end
        ST_WAIT_MEM: begin
          if (_clear && inflight_load_q) suppress_q <= 1'b1;
          if (_mem_done) begin
            state_q    <= ST_IDLE;
            suppress_q <= 1'b0;
            if (inflight_load_q && !suppress_q && !_clear) begin
              cdb_ready_q  <= 1'b1;
              cdb_rob_id_q <= inflight_rob_q;
              cdb_value_q  <= ext_value;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef LSQ_STATS_EN
  logic [31:0] stat_loads_q, stat_stores_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stat_loads_q  <= '0;
      stat_stores_q <= '0;
    end else if (rdy_in && (state_q == ST_WAIT_MEM) && _mem_done) begin
      if (inflight_load_q) begin
        if (stat_loads_q != '1) stat_loads_q <= stat_loads_q + 32'd1;
      end else begin
        if (stat_stores_q != '1) stat_stores_q <= stat_stores_q + 32'd1;
      end
    end
  end

  assign _stat_loads  = stat_loads_q;
  assign _stat_stores = stat_stores_q;
`endif

  assign _lsq_full      = full;
  assign _st_ready      = st_ready_q;
  assign _st_rob_id     = st_rob_id_q;
  assign _mem_req       = mem_req_q;
  assign _mem_we        = mem_we_q;
  assign _mem_addr      = mem_addr_q;
  assign _mem_wdata     = mem_wdata_q;
  assign _mem_width     = mem_width_q;
  assign _cdb_ls_ready  = cdb_ready_q;
  assign _cdb_ls_rob_id = cdb_rob_id_q;
  assign _cdb_ls_value  = cdb_value_q;

endmodule
